pwm_ramp_ctrl: RTL and testbench

- Sequences the duty-cycle input of the team's PWM generator.
- Accepts target duty values over a valid/ready handshake and ramps the `val` output toward each target by a programmable step, once per PWM period.
- Gives soft-start and fade behaviour for LEDs and motors.
- Sits between the control logic and the PWM generator, and shares its clock and reset.

---
 rtl/pwm_ramp_ctrl.sv | 157 +++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl
// -------------
// Sequences the duty value fed to the PWM generator.  A target duty is
// accepted over a valid/ready handshake.  The val output then ramps toward
// that target by a programmable step, once per PWM period.  This gives
// soft-start and fade behaviour for LEDs and motors.
//
// Handshake: a request transfers on a rising clk edge where tgt_valid and
// tgt_ready are both high.  tgt and step are captured on that edge only.  The
// requester holds tgt_valid, tgt and step stable until the transfer.
// tgt_valid is ignored while tgt_ready is low.
//
// Ports:
//   clk        system clock (shared with the PWM generator)
//   rst        asynchronous, active-high reset
//   tgt        requested target duty
//   tgt_valid  tgt holds a request
//   tgt_ready  block can accept a request (IDLE)
//   step       ramp increment per PWM period, captured at acceptance (0 -> 1)
//   abort      stop ramping at once and hold the current val
//   val        duty value driven to the PWM generator
//   busy       ramp in progress
//   done       one-cycle pulse when val reaches the target
module pwm_ramp_ctrl #(
    parameter int LEN = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [LEN-1:0] tgt,
    input  logic           tgt_valid,
    output logic           tgt_ready,
    input  logic [LEN-1:0] step,
    input  logic           abort,
    output logic [LEN-1:0] val,
    output logic           busy,
    output logic           done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [LEN-1:0] cnt;
    logic [LEN-1:0] tgt_l;
    logic [LEN-1:0] step_l;

    logic                  tick;
    logic                  accept;
    logic [LEN:0]          up_sum;
    logic signed [LEN:0]   dn_diff;
    logic [LEN-1:0]        ramp_next;

    // The period counter leaves reset together with the PWM generator.  So
    // tick lines up with the generator's last count, and a val update lands
    // exactly on a period boundary.
    assign tick   = (cnt == {LEN{1'b1}});
    assign accept = tgt_valid && tgt_ready;

    // Both directions use one extra bit, so an overshoot or an underflow is
    // visible.  The result then clamps to the target instead of wrapping.
    assign up_sum  = {1'b0, val} + {1'b0, step_l};
    assign dn_diff = $signed({1'b0, val}) - $signed({1'b0, step_l});

    always_comb begin
        ramp_next = tgt_l;
        if (tgt_l > val) begin
            if (up_sum < {1'b0, tgt_l}) begin
                ramp_next = up_sum[LEN-1:0];
            end
        end else begin
            if (dn_diff > $signed({1'b0, tgt_l})) begin
                ramp_next = dn_diff[LEN-1:0];
            end
        end
    end

    // Free-running period counter; it does not depend on the FSM state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + LEN'(1);
        end
    end

    // Ramp sequencer.  tgt_ready, busy and done are registered.  Each one is
    // loaded with the value that belongs to the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            val       <= '0;
            tgt_l     <= '0;
            step_l    <= LEN'(1);
            tgt_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        tgt_l     <= tgt;
                        step_l    <= (step == '0) ? LEN'(1) : step;
                        tgt_ready <= 1'b0;
                        if (tgt == val) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= RAMP;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end else begin
                        // This branch also raises tgt_ready on the first
                        // edge after reset is released.
                        tgt_ready <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                    end
                end

                RAMP: begin
                    // abort wins over a tick on the same edge: val is frozen.
                    if (abort) begin
                        state     <= IDLE;
                        tgt_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else if (tick) begin
                        val <= ramp_next;
                        if (ramp_next == tgt_l) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    tgt_ready <= 1'b1;
                end

                default: begin
                    state     <= IDLE;
                    tgt_ready <= 1'b1;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Testbench for pwm_ramp_ctrl.
// A request is pushed into exp_q as the list of duty values the ramp must
// take, followed by a completion marker.  The monitor pops one entry per
// observed val change and one per done pulse.  The reference sequence is
// computed from the ramp rules with plain integer arithmetic.
module tb_pwm_ramp_ctrl;

    localparam int LEN    = 8;
    localparam int PERIOD = 1 << LEN;
    localparam int W      = LEN + 1;   // {is_done, value}
    localparam int BOUND  = 20000;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [LEN-1:0] tgt = '0;
    logic           tgt_valid = 1'b0;
    logic           tgt_ready;
    logic [LEN-1:0] step = '0;
    logic           abort = 1'b0;
    logic [LEN-1:0] val;
    logic           busy;
    logic           done;

    pwm_ramp_ctrl #(.LEN(LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .tgt       (tgt),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .step      (step),
        .abort     (abort),
        .val       (val),
        .busy      (busy),
        .done      (done)
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #5 clk = ~clk;

    // Edges since reset release.  The ramp ticks on every edge whose number
    // is a multiple of the PWM period.
    int edge_n;
    always @(posedge clk or posedge rst) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0]   exp_q[$];
    int             n_cmp  = 0;
    int             n_fail = 0;
    int             model_val = 0;
    logic [LEN-1:0] prev_val = '0;
    bit             busy_seen;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic pop_check(input string name, input logic [W-1:0] got);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: unexpected event %0h with nothing expected (t=%0t)", name, got, $time);
        end else begin
            e = exp_q.pop_front();
            check(name, int'(got), int'(e));
        end
    endtask

    // Reference model: the list of values the ramp passes through.
    task automatic push_expected(input int cur, input int t, input int s);
        int s_eff;
        int v;
        s_eff = (s == 0) ? 1 : s;
        v = cur;
        while (v != t) begin
            if (t > v) v = (v + s_eff >= t) ? t : v + s_eff;
            else       v = (v - s_eff <= t) ? t : v - s_eff;
            exp_q.push_back({1'b0, LEN'(v)});
        end
        exp_q.push_back({1'b1, LEN'(t)});
    endtask

    // Monitor: outputs are sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_val = '0;
        end else begin
            if (val !== prev_val) begin
                check("tick_align", edge_n % PERIOD, 0);
                pop_check("val_seq", {1'b0, val});
                prev_val = val;
            end
            if (done) pop_check("done_pulse", {1'b1, val});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int t, input int s);
        int n;
        tgt = LEN'(t);
        step = LEN'(s);
        tgt_valid = 1'b1;
        n = 0;
        while (!tgt_ready && n < BOUND) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= BOUND) check("accept_timeout", n, 0);
        push_expected(model_val, t, s);
        model_val = t;
        @(posedge clk); #1;            // transfer edge
        tgt_valid = 1'b0;
        tgt  = LEN'($urandom);         // captured values must not follow these
        step = LEN'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        busy_seen = 1'b0;
        while ((exp_q.size() != 0 || !tgt_ready) && n < BOUND) begin
            if (busy) busy_seen = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        if (n >= BOUND) check("idle_timeout", n, 0);
        check("idle_busy", busy, 0);
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (edge_n % PERIOD != 0 && n < BOUND);
        @(posedge clk); #1;            // let the monitor consume the update
    endtask

    task automatic hold(input int cycles);
        repeat (cycles) begin
            @(posedge clk); #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t;
        int s;
        int n;

        // Reset and its release.
        #22;
        check("rst_val", val, 0);
        check("rst_ready", tgt_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", tgt_ready, 1);
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);
        check("post_rst_val", val, 0);

        // Rising ramp: 30, 60, 90, 100.
        send(100, 30);
        wait_idle();
        check("rise_busy_seen", busy_seen, 1);
        check("rise_final", val, 100);

        // Falling ramp with saturation: 60, 20, 5.
        send(5, 40);
        wait_idle();
        check("fall_final", val, 5);

        // Target equal to current val: done only, busy never set.
        send(5, 77);
        wait_idle();
        check("eq_busy_seen", busy_seen, 0);
        check("eq_val", val, 5);

        // step = 0 behaves as 1: 6, 7, 8.
        send(8, 0);
        wait_idle();
        check("step0_final", val, 8);

        // Reach 60, then abort a ramp toward 200 before its first tick.
        send(60, 52);
        wait_idle();
        send(200, 70);
        exp_q.delete();
        model_val = 60;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", tgt_ready, 1);
        hold(600);
        check("abort_hold", val, 60);

        // Ramp toward 200 (first step 130), then abort exactly on a tick.
        send(200, 70);
        wait_tick();
        check("pre_tick_abort_val", val, 130);
        exp_q.delete();
        model_val = 130;
        n = 0;
        while (edge_n % PERIOD != PERIOD - 1 && n < BOUND) begin
            @(posedge clk); #1;
            n++;
        end
        abort = 1'b1;
        @(posedge clk); #1;            // tick edge with abort
        abort = 1'b0;
        check("tick_abort_val", val, 130);
        check("tick_abort_busy", busy, 0);
        hold(300);
        check("tick_abort_hold", val, 130);

        // Async reset mid-ramp, between clock edges.
        send(250, 40);
        wait_tick();
        check("pre_rst_val", val, 170);
        #2 rst = 1'b1;
        #1;
        check("async_rst_val", val, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_ready", tgt_ready, 0);
        exp_q.delete();
        model_val = 0;
        @(posedge clk); #3 rst = 1'b0;
        send(90, 30);
        wait_idle();
        check("after_rst_final", val, 90);

        // Randomized requests, sometimes issued while a ramp is still busy.
        for (int i = 0; i < 8; i++) begin
            t = $urandom_range(0, PERIOD - 1);
            s = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(24, PERIOD - 1);
            if (s == 0) t = (model_val > 240) ? model_val - 5 : model_val + 5;
            send(t, s);
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();
        check("rand_final", val, model_val);
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
